// File: rtl/up_to_59.sv
// up_to_59: two-digit BCD elapsed-time counter that flags completion against a latched target
// Ports: clock, reset (sync, active-high); tick count enable; start/stop pulses;
//   target_tens/target_ones sampled on start; tens/ones BCD count; running/done
//   state flags; carry one-cycle wrap pulse.
// Optional UP_TO_59_WRAP_EN: wrap (LIMIT_TENS)9 -> 00 and pulse carry instead of saturating.
module up_to_59 #(
  parameter int LIMIT_TENS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] target_tens,
  input  logic [3:0] target_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       carry
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t     r_state;
  logic [3:0] r_tens, r_ones, r_tgt_tens, r_tgt_ones;
  logic       r_running, r_done;
  logic       w_at_max, w_count, w_adv, w_tgt_ok, w_hit;
  logic [3:0] w_nxt_tens, w_nxt_ones;
  always_comb begin
    w_at_max   = r_tens == 4'(LIMIT_TENS) && r_ones == 4'd9;
    w_count    = tick && !start && !stop && r_state == S_RUN;
    w_nxt_ones = r_ones == 4'd9 ? 4'd0 : r_ones + 4'd1;
`ifdef UP_TO_59_WRAP_EN
    w_adv      = w_count;
    w_nxt_tens = w_at_max ? 4'd0 : (r_ones == 4'd9 ? r_tens + 4'd1 : r_tens);
`else
    w_adv      = w_count && !w_at_max;
    w_nxt_tens = r_ones == 4'd9 ? r_tens + 4'd1 : r_tens;
`endif
    // Target 00 or any digit outside the countable range means free-run.
    w_tgt_ok   = {r_tgt_tens, r_tgt_ones} != 8'h00 && r_tgt_ones <= 4'd9 &&
                 r_tgt_tens <= 4'(LIMIT_TENS);
    w_hit      = w_tgt_ok && w_nxt_tens == r_tgt_tens && w_nxt_ones == r_tgt_ones;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_tgt_tens <= 4'd0;
      r_tgt_ones <= 4'd0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else if (stop) begin
      if (r_state == S_RUN) begin
        r_state   <= S_IDLE;
        r_running <= 1'b0;
      end
    end else if (start) begin
      r_state    <= S_RUN;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_tgt_tens <= target_tens;
      r_tgt_ones <= target_ones;
      r_running  <= 1'b1;
      r_done     <= 1'b0;
    end else if (w_adv) begin
      r_tens <= w_nxt_tens;
      r_ones <= w_nxt_ones;
      if (w_hit) begin
        r_state   <= S_DONE;
        r_running <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end
`ifdef UP_TO_59_WRAP_EN
  logic r_carry;
  always_ff @(posedge clock) r_carry <= !reset && w_count && w_at_max;
  assign carry = r_carry;
`else
  assign carry = 1'b0;
`endif
  assign tens    = r_tens;
  assign ones    = r_ones;
  assign running = r_running;
  assign done    = r_done;
endmodule

// File: tb/tb_up_to_59.sv
// tb_up_to_59: randomized and directed self-checking bench for up_to_59
module tb_up_to_59;
  localparam int L = 5;
  logic       clock = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] target_tens = 4'd0, target_ones = 4'd0;
  logic [3:0] tens, ones;
  logic       running, done, carry;
  int         checks = 0, errors = 0;
  int         m_cnt, m_tgt;
  bit         m_run, m_done, m_carry, m_ok;

  up_to_59 #(.LIMIT_TENS(L)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .target_tens(target_tens), .target_ones(target_ones),
    .tens(tens), .ones(ones), .running(running), .done(done), .carry(carry)
  );

  always #5 clock = ~clock;

  // Reference: count kept as a plain integer seconds value, state as two flags.
  function automatic void model(bit tk, bit st, bit sp, bit rs, int tt, int to);
    m_carry = 0;
    if (rs) begin
      m_cnt = 0; m_tgt = 0; m_ok = 0; m_run = 0; m_done = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (st) begin
      m_cnt = 0; m_tgt = tt * 10 + to; m_run = 1; m_done = 0;
      m_ok = tt <= L && to <= 9 && m_tgt != 0;
    end else if (tk && m_run) begin
      if (m_cnt == L * 10 + 9) begin
`ifdef UP_TO_59_WRAP_EN
        m_cnt = 0; m_carry = 1;
`endif
      end else begin
        m_cnt++;
        if (m_ok && m_cnt == m_tgt) begin m_run = 0; m_done = 1; end
      end
    end
  endfunction

  function automatic logic [10:0] exp_vec();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), m_run, m_done, m_carry};
  endfunction

  task automatic step(bit tk, bit st, bit sp, bit rs, logic [3:0] tt, logic [3:0] to);
    tick = tk; start = st; stop = sp; reset = rs; target_tens = tt; target_ones = to;
    model(tk, st, sp, rs, int'(tt), int'(to));
    @(posedge clock); #1;
    tick = 0; start = 0; stop = 0; reset = 0;
  endtask

  task automatic test_reset();
    step(0, 1, 0, 1, 4'd3, 4'd3);
    checks++;
    if ({tens, ones, running, done, carry} !== 11'd0) begin
      errors++; $display("FAIL reset got %h exp %h", {tens, ones, running, done, carry}, 11'd0);
    end
  endtask

  task automatic test_target03();
    step(0, 1, 0, 0, 4'd0, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 4'd0, 4'd0);
      checks++;
      if ({tens, ones, running, done} !== {8'(i > 3 ? 3 : i), i < 3, i >= 3}) begin
        errors++; $display("FAIL t03_tick%0d got %h%h r%b d%b", i, tens, ones, running, done);
      end
    end
  endtask

  task automatic test_target12();
    step(0, 1, 0, 0, 4'd1, 4'd2);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0, 4'd0, 4'd0);
      checks++;
      if ({tens, ones, running, done, carry} !== exp_vec()) begin
        errors++; $display("FAIL t12_tick%0d got %h exp %h", i, {tens, ones, running, done, carry}, exp_vec());
      end
    end
    checks++;
    if ({tens, ones, done} !== {8'h12, 1'b1}) begin
      errors++; $display("FAIL t12_done got %h%h d%b exp 12 d1", tens, ones, done);
    end
  endtask

  task automatic test_overflow();
    step(0, 1, 0, 0, 4'd0, 4'd0);
    for (int i = 1; i <= 61; i++) begin
      step(1, 0, 0, 0, 4'd0, 4'd0);
      checks++;
      if ({tens, ones, running, done, carry} !== exp_vec()) begin
        errors++; $display("FAIL ovf_tick%0d got %h exp %h", i, {tens, ones, running, done, carry}, exp_vec());
      end
      if (i == 60) begin
        checks++;
`ifdef UP_TO_59_WRAP_EN
        if ({tens, ones, running, done, carry} !== {8'h00, 3'b101}) begin
`else
        if ({tens, ones, running, done, carry} !== {8'h59, 3'b100}) begin
`endif
          errors++; $display("FAIL ovf_edge got %h%h r%b d%b c%b", tens, ones, running, done, carry);
        end
      end
    end
  endtask

  task automatic test_start_stop_tick();
    step(0, 1, 0, 0, 4'd0, 4'd0);
    repeat (7) step(1, 0, 0, 0, 4'd0, 4'd0);
    step(1, 1, 1, 0, 4'd0, 4'd1);
    checks++;
    if ({tens, ones, running, done} !== {8'h07, 2'b00}) begin
      errors++; $display("FAIL sst_hold got %h%h r%b d%b exp 07 r0 d0", tens, ones, running, done);
    end
    step(1, 0, 0, 0, 4'd0, 4'd0);
    checks++;
    if ({tens, ones, running} !== {8'h07, 1'b0}) begin
      errors++; $display("FAIL sst_idle_tick got %h%h r%b exp 07 r0", tens, ones, running);
    end
  endtask

  task automatic test_reset_midrun();
    step(0, 1, 0, 0, 4'd0, 4'd0);
    repeat (25) step(1, 0, 0, 0, 4'd0, 4'd0);
    checks++;
    if ({tens, ones} !== 8'h25) begin
      errors++; $display("FAIL rst_pre got %h%h exp 25", tens, ones);
    end
    step(1, 0, 0, 1, 4'd0, 4'd0);
    checks++;
    if ({tens, ones, running, done, carry} !== 11'd0) begin
      errors++; $display("FAIL rst_mid got %h exp 000", {tens, ones, running, done, carry});
    end
  endtask

  task automatic test_out_of_range();
    step(0, 1, 0, 0, 4'd7, 4'd0);
    for (int i = 1; i <= 75; i++) begin
      step(1, 0, 0, 0, 4'd0, 4'd0);
      checks++;
      if ({tens, ones, running, done, carry} !== exp_vec() || done !== 1'b0) begin
        errors++; $display("FAIL oor_tick%0d got %h exp %h", i, {tens, ones, running, done, carry}, exp_vec());
      end
    end
    step(1, 1, 0, 0, 4'd0, 4'd5);
    checks++;
    if ({tens, ones, running, done} !== {8'h00, 2'b10}) begin
      errors++; $display("FAIL oor_restart got %h%h r%b d%b exp 00 r1 d0", tens, ones, running, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 400) == 0, 4'($urandom_range(0, 15) > 11 ? $urandom_range(6, 15) : $urandom_range(0, 5)),
           4'($urandom_range(0, 15)));
      checks++;
      if ({tens, ones, running, done, carry} !== exp_vec()) begin
        errors++; $display("FAIL rand%0d got %h exp %h", i, {tens, ones, running, done, carry}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_target03();
    test_target12();
    test_overflow();
    test_start_stop_tick();
    test_reset_midrun();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_to_59.md
# up_to_59

Two-digit BCD elapsed-time counter for the irrigation timer: counts up from 00 on a 1 Hz tick enable and raises `done` when the latched target duration is reached. It complements the per-digit BCD down counters. Those count a programmed interval down to zero; this block measures how long a valve has been open and reports completion against a target. It sits between the tick prescaler and the valve controller, and drives the display digit buses directly.

## Interface
Parameters:
- `LIMIT_TENS`, default 5: highest tens digit, so the count spans 00..(LIMIT_TENS)9. Legal range is 1..9.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `tick`  in  1  count enable, one-cycle pulse per second.
- `start`  in  1  pulse; clears the count, latches the target and begins running.
- `stop`  in  1  pulse; halts counting and holds the count.
- `target_tens`  in  4  BCD tens digit of the duration, sampled on `start`.
- `target_ones`  in  4  BCD ones digit of the duration, sampled on `start`.
- `tens`  out  4  BCD tens digit of the count (registered).
- `ones`  out  4  BCD ones digit of the count (registered).
- `running`  out  1  high while in RUNNING.
- `done`  out  1  level; high while in DONE.
- `carry`  out  1  one-cycle pulse on wrap. Present only with `UP_TO_59_WRAP_EN`; otherwise tied to 0.

## Operation
- States: IDLE, RUNNING, DONE. Reset values: state IDLE, `tens`=0, `ones`=0, `running`=0, `done`=0, `carry`=0, target register 00.
- `start` in any state (absent `stop`):
  - count ← 00, target register ← {`target_tens`,`target_ones`}, next state RUNNING.
  - A `tick` in the same cycle is ignored.
- `stop` in RUNNING: next state IDLE, count held.
  - `stop` in IDLE or DONE has no effect.
  - If `start` and `stop` arrive in the same cycle, `stop` wins and `start` is ignored entirely; the target is not latched.
- `tick` in RUNNING (no `start`/`stop`):
  - `ones` 0..8 → `ones`+1.
  - `ones`=9 → `ones`=0 and `tens`+1.
  - Count = (LIMIT_TENS)9 → overflow; see Configuration.
- `tick` in IDLE or DONE is ignored.
- Completion compare:
  - Evaluated on the post-increment count at each counted tick.
  - Equal to the target → next state DONE, count holds at the target.
- Target 00, `target_ones`>9, `target_tens`>LIMIT_TENS, or `target_tens`>9 → free-run. The block never enters DONE for that run.
- Outputs are always valid BCD. Digit values 10..15 never appear on `tens` or `ones`.

## Timing
- Count latency: the edge that samples `tick` updates `tens`/`ones`. New values are visible one cycle after the `tick` cycle.
- `running` rises on the edge after `start` and falls on the edge after `stop` or on the completion edge.
- `done` rises on the same edge that loads the final count. It stays high until `start` or `reset`.
- `start` from DONE: `done` falls and `running` rises on the same edge; the count reads 00 the next cycle.
- `reset` asserted mid-run: all outputs return to their reset values on that edge. Any `tick`, `start` or `stop` in the same cycle is ignored.
- `carry`, when compiled in, is high for exactly the one cycle after the wrapping tick.
- Back-to-back ticks on consecutive cycles must each count. There is no minimum tick spacing.

## Configuration
- `UP_TO_59_WRAP_EN` defined: overflow at (LIMIT_TENS)9 wraps the count to 00 and pulses `carry`. A free-running timer continues indefinitely.
- `UP_TO_59_WRAP_EN` undefined:
  - Overflow saturates; the count holds at (LIMIT_TENS)9 and further ticks are ignored while RUNNING.
  - `running` stays high.
  - `carry` is constant 0.

## Test plan
- Reset, then `start` with target 03 and 3 ticks → count 01, 02, 03. `done`=1 and `running`=0 on the third update. A 4th tick leaves the count at 03.
- Target 12, default LIMIT_TENS → the tick after count 09 yields 10 (ones wraps 9→0, tens 0→1). `done` rises at 12.
- `start` with target 00, 60 ticks, WRAP_EN defined → count reaches 59, then 00. `carry` is high for one cycle and `done` stays 0. With the macro undefined, the count holds at 59 and `carry`=0.
- RUNNING at 07: `start`, `stop` and `tick` in one cycle → IDLE with count 07 held. A following tick leaves the count at 07.
- RUNNING at 25: `reset` together with `tick` → next cycle 00, IDLE, all flags 0.
- Target tens=7 (out of range for LIMIT_TENS=5) → free-run and `done` never asserts. `start` again in the same cycle as `tick` → count 00 and the tick is not counted.
